// File: rtl/ahb_lite_decoder_mux_if.sv
// AHB-Lite bus bundle between one master, three slaves plus a default slave, and the decoder/mux.
// The slave modport is the decoder's view; the master modport is the mirror used to drive it.
interface ahb_lite_decoder_mux_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HSEL_S0;
  logic        HSEL_S1;
  logic        HSEL_S2;
  logic        HSEL_DEF;
  logic [31:0] HRDATA_S0;
  logic [31:0] HRDATA_S1;
  logic [31:0] HRDATA_S2;
  logic [31:0] HRDATA_DEF;
  logic        HREADYOUT_S0;
  logic        HREADYOUT_S1;
  logic        HREADYOUT_S2;
  logic        HREADYOUT_DEF;
  logic [1:0]  HRESP_S0;
  logic [1:0]  HRESP_S1;
  logic [1:0]  HRESP_S2;
  logic [1:0]  HRESP_DEF;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport slave (
    input  HADDR, HTRANS,
    input  HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_DEF,
    input  HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_DEF,
    input  HRESP_S0, HRESP_S1, HRESP_S2, HRESP_DEF,
    output HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF,
    output HRDATA, HREADY, HRESP
  );

  modport master (
    output HADDR, HTRANS,
    output HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_DEF,
    output HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_DEF,
    output HRESP_S0, HRESP_S1, HRESP_S2, HRESP_DEF,
    input  HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF,
    input  HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and response mux for three slaves plus a default slave.
// Optional error logger enabled by defining AHB_DEC_ERRLOG_EN.
module ahb_lite_decoder_mux #(
  parameter logic [3:0] S0_BASE = 4'h0,
  parameter logic [3:0] S1_BASE = 4'h1,
  parameter logic [3:0] S2_BASE = 4'h2
) (
  input logic HCLK,
  input logic HRESETN,
  ahb_lite_decoder_mux_if.slave bus
`ifdef AHB_DEC_ERRLOG_EN
  ,
  input  logic        err_clr,
  output logic [15:0] err_cnt,
  output logic [31:0] err_addr
`endif
);

  typedef enum logic [2:0] {
    DSEL_NONE = 3'd0,
    DSEL_S0   = 3'd1,
    DSEL_S1   = 3'd2,
    DSEL_S2   = 3'd3,
    DSEL_DEF  = 3'd4
  } dsel_t;

  dsel_t addr_sel;
  dsel_t dsel;
  dsel_t dsel_next;
  logic  unused_bits;

  // Only the top nibble decodes; the rest of the address feeds the error logger when present.
  assign unused_bits = ^{bus.HADDR[27:0], bus.HTRANS[0]};

  // Address-phase decode; priority order keeps exactly one select high even with overlapping bases.
  always_comb begin
    addr_sel = DSEL_DEF;
    if (bus.HADDR[31:28] == S0_BASE) begin
      addr_sel = DSEL_S0;
    end else if (bus.HADDR[31:28] == S1_BASE) begin
      addr_sel = DSEL_S1;
    end else if (bus.HADDR[31:28] == S2_BASE) begin
      addr_sel = DSEL_S2;
    end else begin
      addr_sel = DSEL_DEF;
    end
  end

  assign bus.HSEL_S0  = (addr_sel == DSEL_S0);
  assign bus.HSEL_S1  = (addr_sel == DSEL_S1);
  assign bus.HSEL_S2  = (addr_sel == DSEL_S2);
  assign bus.HSEL_DEF = (addr_sel == DSEL_DEF);

  // Data-phase select register.
  always_ff @(posedge HCLK or posedge HRESETN) begin
    if (HRESETN) begin
      dsel <= DSEL_NONE;
    end else begin
      dsel <= dsel_next;
    end
  end

  // Advance only when the current data phase completes; IDLE/BUSY leave no slave owning the next one.
  always_comb begin
    dsel_next = dsel;
    if (bus.HREADY) begin
      if (bus.HTRANS[1]) begin
        dsel_next = addr_sel;
      end else begin
        dsel_next = DSEL_NONE;
      end
    end else begin
      dsel_next = dsel;
    end
  end

  // Response mux; any unused encoding behaves as an idle data phase.
  always_comb begin
    bus.HRDATA = 32'h0000_0000;
    bus.HREADY = 1'b1;
    bus.HRESP  = 2'b00;
    case (dsel)
      DSEL_S0: begin
        bus.HRDATA = bus.HRDATA_S0;
        bus.HREADY = bus.HREADYOUT_S0;
        bus.HRESP  = bus.HRESP_S0;
      end
      DSEL_S1: begin
        bus.HRDATA = bus.HRDATA_S1;
        bus.HREADY = bus.HREADYOUT_S1;
        bus.HRESP  = bus.HRESP_S1;
      end
      DSEL_S2: begin
        bus.HRDATA = bus.HRDATA_S2;
        bus.HREADY = bus.HREADYOUT_S2;
        bus.HRESP  = bus.HRESP_S2;
      end
      DSEL_DEF: begin
        bus.HRDATA = bus.HRDATA_DEF;
        bus.HREADY = bus.HREADYOUT_DEF;
        bus.HRESP  = bus.HRESP_DEF;
      end
      default: begin
        bus.HRDATA = 32'h0000_0000;
        bus.HREADY = 1'b1;
        bus.HRESP  = 2'b00;
      end
    endcase
  end

`ifdef AHB_DEC_ERRLOG_EN
  logic [31:0] data_addr;
  logic        err_hit;

  assign err_hit = bus.HREADY && (bus.HRESP == 2'b01) && (dsel != DSEL_NONE);

  // Address of the transfer currently in its data phase.
  always_ff @(posedge HCLK or posedge HRESETN) begin
    if (HRESETN) begin
      data_addr <= 32'h0000_0000;
    end else if (bus.HREADY && bus.HTRANS[1]) begin
      data_addr <= bus.HADDR;
    end
  end

  // Saturating error counter; a clear takes precedence over a coincident error.
  always_ff @(posedge HCLK or posedge HRESETN) begin
    if (HRESETN) begin
      err_cnt <= 16'h0000;
    end else if (err_clr) begin
      err_cnt <= 16'h0000;
    end else if (err_hit && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h0001;
    end
  end

  // Last failing address survives a counter clear.
  always_ff @(posedge HCLK or posedge HRESETN) begin
    if (HRESETN) begin
      err_addr <= 32'h0000_0000;
    end else if (err_hit) begin
      err_addr <= data_addr;
    end
  end
`endif

endmodule

// File: doc/ahb_lite_decoder_mux.md
AHB_LITE_DECODER_MUX -- requirements
Module: ahb_lite_decoder_mux

Interface
REQ-001 SHALL have parameter S0_BASE, default 4'h0: HADDR[31:28] value selecting slave 0.
REQ-002 SHALL have parameter S1_BASE, default 4'h1: HADDR[31:28] value selecting slave 1.
REQ-003 SHALL have parameter S2_BASE, default 4'h2: HADDR[31:28] value selecting slave 2.
REQ-004 SHALL have ports:
- HCLK  in  1  system clock, single clock domain.
- HRESETN  in  1  asynchronous reset, active-high (asserted = 1).
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type.
- HSEL_S0, HSEL_S1, HSEL_S2, HSEL_DEF  out  1 each  address-phase slave selects; HSEL_DEF drives the default slave.
- HRDATA_S0..S2, HRDATA_DEF  in  32 each  slave read data.
- HREADYOUT_S0..S2, HREADYOUT_DEF  in  1 each  slave ready.
- HRESP_S0..S2, HRESP_DEF  in  2 each  slave response (00 OKAY, 01 ERROR).
- HRDATA  out  32  muxed read data to master.
- HREADY  out  1  muxed ready, fed back to master and all slaves.
- HRESP  out  2  muxed response to master.

Function
REQ-005 SHALL decode HSEL_* combinationally from HADDR[31:28]: match S0/S1/S2_BASE -> that select; no match -> HSEL_DEF; exactly one select high at all times, independent of HTRANS.
REQ-006 SHALL hold a data-phase select register DSEL with states NONE, S0, S1, S2, DEF.
REQ-007 SHALL update DSEL only on a rising HCLK edge with HREADY=1: HTRANS[1]=1 (NONSEQ/SEQ) -> decoded slave; HTRANS[1]=0 (IDLE/BUSY) -> NONE.
REQ-008 SHALL hold DSEL unchanged while HREADY=0 (wait-stated data phase).
REQ-009 SHALL drive HRDATA/HREADY/HRESP combinationally from the slave named by DSEL; in NONE drive HRDATA=0, HREADY=1, HRESP=00.
REQ-010 SHALL add zero latency: slave outputs reach master in the same cycle; DSEL takes effect the cycle after the address phase completes.
REQ-011 SHALL pass two-cycle ERROR responses unaltered (first cycle HREADY=0/HRESP=01, second HREADY=1/HRESP=01).
REQ-012 SHALL treat back-to-back transfers to different slaves as a DSEL change on each HREADY=1 edge, with no bubble cycle.
REQ-013 SHALL treat a DSEL encoding outside the five states as NONE.

Reset
REQ-014 SHALL on HRESETN=1, immediately and without HCLK, set DSEL=NONE, giving HREADY=1, HRESP=00, HRDATA=0.
REQ-015 SHALL on reset mid-transfer abandon the data phase; the first transfer after HRESETN deasserts is decoded normally.
REQ-016 SHALL keep HSEL_* purely combinational, unaffected by reset.

Configuration
REQ-017 SHALL, with macro AHB_DEC_ERRLOG_EN defined, add inputs err_clr (1) and outputs err_cnt (16), err_addr (32); without it, these ports and their logic SHALL be absent and behaviour otherwise identical.
REQ-018 SHALL, when enabled, register HADDR at each completed address phase with HTRANS[1]=1 as the data-phase address.
REQ-019 SHALL, when enabled, increment err_cnt (saturating at 16'hFFFF) and load err_addr with the data-phase address on each cycle with HREADY=1, HRESP=01 and DSEL!=NONE.
REQ-020 SHALL, when enabled, zero err_cnt on err_clr=1; err_clr wins over a simultaneous increment; err_addr is kept; reset zeroes both.

Verification
REQ-021 Reset: HRESETN=1 with HREADYOUT_S0=0 and prior DSEL=S0 -> HREADY=1, HRESP=00, HRDATA=0 in the same cycle.
REQ-022 Decode/read: NONSEQ read at 0x1000_0040, HRDATA_S1=0xCAFE_0001 -> HSEL_S1=1 in the address phase; HRDATA=0xCAFE_0001, HREADY=1 the next cycle.
REQ-023 Wait states: NONSEQ to 0x0000_0000, HREADYOUT_S0=0 for 3 cycles, next address 0x2000_0000 -> HREADY=0 for 3 cycles, DSEL stays S0, then switches to S2.
REQ-024 Default slave: NONSEQ write to 0x7000_0000 -> HSEL_DEF=1; data phase passes HRESP_DEF=01 for two cycles (HREADY 0 then 1).
REQ-025 IDLE: HTRANS=00 at 0x1000_0000 -> next cycle DSEL=NONE, HREADY=1, HRESP=00 regardless of HREADYOUT_S1=0.
REQ-026 Errlog (AHB_DEC_ERRLOG_EN): two ERROR responses at 0x7000_0010 and 0x7000_0020 -> err_cnt=2, err_addr=0x7000_0020; err_clr pulse -> err_cnt=0, err_addr=0x7000_0020.
